// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first.
// Results (sum, cout, ovf) are loaded together on entry to DONE and held until the next one.
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, shift_q, shift_d, sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mode_q, mode_d, carry_q, carry_d;
  logic             busy_q, busy_d, done_q, done_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             a_bit, b_eff, res_bit, carry_nx;

  always_comb begin
    a_bit    = a_q[cnt_q];
    b_eff    = b_q[cnt_q] ^ mode_q;
    res_bit  = a_bit ^ b_eff ^ carry_q;
    carry_nx = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          carry_d = mode;  // carry-in of 1 completes the two's complement of b
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        shift_d = {res_bit, shift_q[WIDTH-1:1]};
        carry_d = carry_nx;
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          sum_d   = {res_bit, shift_q[WIDTH-1:1]};
          cout_d  = carry_nx;
          ovf_d   = carry_q ^ carry_nx;  // carry into MSB xor carry out of MSB
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (WIDTH 4, 8, 16) driven by directed tables,
// corner-case sequences and a randomised run against an independent arithmetic model.
module tb_serial_addsub;

  logic        clk;
  logic [2:0]  rst_v, start_v, mode_v, busy_v, done_v, cout_v, ovf_v;
  logic [15:0] a_v [3];
  logic [15:0] b_v [3];
  logic [15:0] sum_v [3];
  logic [3:0]  sum4;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  int checks = 0;
  int errors = 0;
  int wid [3] = '{4, 8, 16};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_v[0][3:0]), .b(b_v[0][3:0]),
    .mode(mode_v[0]), .busy(busy_v[0]), .done(done_v[0]), .sum(sum4), .cout(cout_v[0]),
    .ovf(ovf_v[0])
  );
  serial_addsub #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_v[1][7:0]), .b(b_v[1][7:0]),
    .mode(mode_v[1]), .busy(busy_v[1]), .done(done_v[1]), .sum(sum8), .cout(cout_v[1]),
    .ovf(ovf_v[1])
  );
  serial_addsub #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .mode(mode_v[2]), .busy(busy_v[2]), .done(done_v[2]), .sum(sum16), .cout(cout_v[2]),
    .ovf(ovf_v[2])
  );

  always_comb begin
    sum_v[0] = {12'b0, sum4};
    sum_v[1] = {8'b0, sum8};
    sum_v[2] = sum16;
  end

  typedef struct {
    int          k;
    logic [15:0] a;
    logic [15:0] b;
    logic        m;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from a + (m ? ~b : b) + m, overflow from operand/result signs.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic m);
    logic [16:0] mask, aa, bb, full;
    logic        o;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = (m ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + {16'b0, m};
    o    = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {o, full[w], full[15:0] & mask[15:0]};
  endfunction

  task automatic do_op(input int k, input logic [15:0] ai, input logic [15:0] bi,
                       input logic mi, output logic [15:0] s, output logic c,
                       output logic o, output int lat);
    @(negedge clk);
    a_v[k] = ai; b_v[k] = bi; mode_v[k] = mi; start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    lat = -1;
    s = 'x; c = 1'bx; o = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_v[k]) begin
        lat = n; s = sum_v[k]; c = cout_v[k]; o = ovf_v[k];
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL timeout: no done on instance %0d", k);
    end
    @(posedge clk); #1;  // DONE -> IDLE
  endtask

  vec_t        vecs [8];
  logic [15:0] s;
  logic        c, o;
  int          lat;

  initial begin
    int busy_cnt, done_cnt, d1, b2;
    logic [15:0] s1;
    logic [17:0] exp_r;

    vecs[0] = '{0, 16'h000A, 16'h0002, 1'b0, 16'h000C, 1'b0, 1'b0};
    vecs[1] = '{0, 16'h000A, 16'h0001, 1'b1, 16'h0009, 1'b1, 1'b0};
    vecs[2] = '{0, 16'h0008, 16'h000B, 1'b1, 16'h000D, 1'b0, 1'b0};
    vecs[3] = '{0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{1, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b1};
    vecs[5] = '{1, 16'h0080, 16'h0001, 1'b1, 16'h007F, 1'b1, 1'b1};
    vecs[6] = '{2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{2, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

    rst_v = 3'b111; start_v = '0; mode_v = '0;
    for (int i = 0; i < 3; i++) begin a_v[i] = '0; b_v[i] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_v = '0;
    for (int i = 0; i < 3; i++) begin
      chk("reset_busy", 32'(busy_v[i]), 32'd0);
      chk("reset_done", 32'(done_v[i]), 32'd0);
      chk("reset_sum", 32'(sum_v[i]), 32'd0);
      chk("reset_cout", 32'(cout_v[i]), 32'd0);
      chk("reset_ovf", 32'(ovf_v[i]), 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].m, s, c, o, lat);
      chk($sformatf("vec%0d_sum", i), 32'(s), 32'(vecs[i].sum));
      chk($sformatf("vec%0d_cout", i), 32'(c), 32'(vecs[i].cout));
      chk($sformatf("vec%0d_ovf", i), 32'(o), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(wid[vecs[i].k]));
    end

    // start pulses with new operands during RUN are ignored
    @(negedge clk);
    a_v[1] = 16'h12; b_v[1] = 16'h34; mode_v[1] = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    busy_cnt = busy_v[1] ? 1 : 0;
    done_cnt = 0;
    s1 = 'x;
    for (int n = 1; n <= 20; n++) begin
      if (n == 2 || n == 5) begin
        start_v[1] = 1'b1; a_v[1] = 16'hFF; b_v[1] = 16'hFF; mode_v[1] = 1'b1;
      end else begin
        start_v[1] = 1'b0;
      end
      @(posedge clk); #1;
      if (busy_v[1]) busy_cnt++;
      if (done_v[1]) begin done_cnt++; s1 = sum_v[1]; end
    end
    start_v[1] = 1'b0;
    chk("ignore_start_sum", 32'(s1), 32'h46);
    chk("ignore_start_done_count", 32'(done_cnt), 32'd1);
    chk("ignore_start_busy_cycles", 32'(busy_cnt), 32'd8);

    // reset at cycle 3 of RUN aborts the operation
    @(negedge clk);
    a_v[1] = 16'h55; b_v[1] = 16'h11; mode_v[1] = 1'b0; start_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_v[1] = 1'b1;
    @(posedge clk); #1;
    rst_v[1] = 1'b0;
    chk("midrun_rst_busy", 32'(busy_v[1]), 32'd0);
    chk("midrun_rst_sum", 32'(sum_v[1]), 32'd0);
    chk("midrun_rst_cout", 32'(cout_v[1]), 32'd0);
    chk("midrun_rst_ovf", 32'(ovf_v[1]), 32'd0);
    done_cnt = done_v[1] ? 1 : 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done_v[1]) done_cnt++;
    end
    chk("midrun_rst_no_done", 32'(done_cnt), 32'd0);
    do_op(1, 16'hFF, 16'h01, 1'b0, s, c, o, lat);
    chk("after_rst_sum", 32'(s), 32'h00);
    chk("after_rst_cout", 32'(c), 32'd1);
    chk("after_rst_ovf", 32'(o), 32'd0);

    // start held high: one IDLE cycle between done and the next capture
    @(negedge clk);
    a_v[0] = 16'h3; b_v[0] = 16'h4; mode_v[0] = 1'b0; start_v[0] = 1'b1;
    d1 = -1; b2 = -1; s1 = 'x;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (d1 < 0 && done_v[0]) begin d1 = n; s1 = sum_v[0]; end
      else if (d1 >= 0 && b2 < 0 && busy_v[0]) b2 = n;
    end
    start_v[0] = 1'b0;
    repeat (12) @(posedge clk);
    chk("b2b_sum", 32'(s1), 32'h7);
    chk("b2b_gap", 32'(b2 - d1), 32'd2);

    // randomised run across the three widths
    for (int i = 0; i < 1000; i++) begin
      int k;
      logic [15:0] ra, rb;
      logic rm;
      k  = i % 3;
      ra = 16'($urandom) & 16'((32'd1 << wid[k]) - 1);
      rb = 16'($urandom) & 16'((32'd1 << wid[k]) - 1);
      rm = 1'($urandom);
      exp_r = ref_model(wid[k], ra, rb, rm);
      do_op(k, ra, rb, rm, s, c, o, lat);
      chk($sformatf("rand%0d_w%0d_%h_%h_%0d", i, wid[k], ra, rb, rm), {14'b0, o, c, s}, {14'b0, exp_r});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal range is 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b).
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress (RUN).
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking valid new results.
REQ-010 The block SHALL have port sum, output, WIDTH bits: result, modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of the MSB; in subtract mode, 1 = no borrow (a >= b unsigned).
REQ-012 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at edge E0 SHALL have these effects:
- capture a, b and mode into internal registers;
- initialise the carry register to mode;
- clear the bit counter;
- enter RUN.
REQ-015 In IDLE, start=0 SHALL leave IDLE unchanged.
REQ-016 In RUN, the block SHALL process one bit per edge, LSB first, with edges E1..E(WIDTH) producing bits 0..WIDTH-1.
REQ-017 For each RUN bit, the effective b bit SHALL be b[i] XOR captured mode.
REQ-018 For each RUN bit, the result bit SHALL be a[i] XOR beff XOR carry, and the next carry SHALL be the full-adder majority of the same three terms.
REQ-019 The bit counter SHALL wrap from WIDTH-1; at edge E(WIDTH) the FSM SHALL enter DONE.
REQ-020 At edge E(WIDTH) the block SHALL load sum, cout and ovf together.
REQ-021 ovf SHALL be the final carry into the MSB XOR the final carry out of the MSB.
REQ-022 done SHALL be 1 only in DONE, for exactly one cycle.
REQ-023 At edge E(WIDTH+1) the FSM SHALL return to IDLE unconditionally.
REQ-024 Start-to-done latency SHALL be WIDTH cycles, and start-to-IDLE latency SHALL be WIDTH+1 cycles.
REQ-025 busy SHALL be 1 exactly in RUN (cycles after E0 through E(WIDTH)).
REQ-026 sum, cout and ovf SHALL change only at a DONE entry or at reset, and SHALL hold their values through later RUN periods until the next DONE.
REQ-027 start in RUN or DONE SHALL be ignored: no queuing and no restart.
REQ-028 A change of a, b or mode after E0 SHALL NOT affect the operation in progress.
REQ-029 start held high continuously SHALL cause back-to-back operations with one IDLE cycle between done and the next capture.
REQ-030 Arithmetic SHALL be exactly equal to the (WIDTH+1)-bit result of a + (mode ? ~b : b) + mode, for every legal WIDTH.

Reset
REQ-031 rst=1 at any edge SHALL force IDLE and set busy=0, done=0, sum=0, cout=0 and ovf=0.
REQ-032 rst=1 SHALL clear the internal operand, carry and counter registers.
REQ-033 rst SHALL take priority over start and over any FSM transition.
REQ-034 Reset mid-RUN SHALL abort the operation: no done pulse, and outputs return to 0.
REQ-035 After rst is released, the block SHALL accept start on the first edge with rst=0.

Verification
REQ-036 With WIDTH=4, a=1010, b=0010, mode=0, start -> done exactly 4 cycles later with sum=1100, cout=0, ovf=0.
REQ-037 With WIDTH=4, two operations:
- a=1010, b=0001, mode=1 -> sum=1001, cout=1, ovf=0;
- a=1000, b=1011, mode=1 -> sum=1101, cout=0 (borrow), ovf=0.
REQ-038 With WIDTH=8, two operations:
- a=0x7F, b=0x01, mode=0 -> sum=0x80, cout=0, ovf=1;
- a=0x80, b=0x01, mode=1 -> sum=0x7F, cout=1, ovf=1.
REQ-039 With WIDTH=8, pulsing start with new operands during RUN -> the first result is unchanged, exactly one done pulse occurs, and busy stays high for exactly 8 cycles.
REQ-040 With WIDTH=8, asserting rst at cycle 3 of RUN -> the bench SHALL check all of the following:
- busy=0, done never pulses, sum=0;
- a subsequent start of 0xFF+0x01 add gives sum=0x00, cout=1, ovf=0.
REQ-041 A randomised run of 1000 operations at WIDTH=4, 8 and 16 SHALL match the REQ-030 reference model on every done pulse.
